unidade_load_store: RTL and testbench

- Load/store controller between the datapath memory stage and the word-addressed data RAM (`ram_dados`).
- Accepts byte-addressed loads and stores of byte, halfword or word size.
- Sub-word stores are done as read-modify-write on the RAM word.
- Loads return a zero- or sign-extended 32-bit result, and each access completes with a one-cycle `pronto` pulse.

---
 rtl/unidade_load_store_if.sv | 32 +++
 rtl/unidade_load_store.sv | 170 +++++++++++++++++
 tb/tb_unidade_load_store.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/unidade_load_store_if.sv
// Bundle between the memory stage / data RAM and the load/store controller.
interface unidade_load_store_if;
    logic        inicio;
    logic        escrita;
    logic [1:0]  tamanho;
    logic        sinal;
    logic [31:0] endereco;
    logic [31:0] dado_escrita;
    logic [31:0] dado_leitura;
    logic        pronto;
    logic        erro_alinhamento;
    logic        ocupado;
    logic [31:0] ram_endereco;
    logic [31:0] ram_entrada;
    logic        ram_we;
    logic        ram_re;
    logic [31:0] ram_saida;

    // Controller side: takes requests and RAM read data, drives results and RAM strobes.
    modport slave (
        input  inicio, escrita, tamanho, sinal, endereco, dado_escrita, ram_saida,
        output dado_leitura, pronto, erro_alinhamento, ocupado,
        ram_endereco, ram_entrada, ram_we, ram_re
    );

    // Environment side: datapath issuing requests plus the data RAM.
    modport master (
        output inicio, escrita, tamanho, sinal, endereco, dado_escrita, ram_saida,
        input  dado_leitura, pronto, erro_alinhamento, ocupado,
        ram_endereco, ram_entrada, ram_we, ram_re
    );
endinterface

// File: rtl/unidade_load_store.sv
// Byte/halfword/word load-store controller for a word-addressed data RAM.
// Sub-word stores are read-modify-write; loads return an extended 32-bit lane.
module unidade_load_store #(
    parameter int unsigned RAM_PALAVRAS = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    unidade_load_store_if.slave  bus
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        LER      = 2'd1,
        ESCREVER = 2'd2,
        CONCLUIR = 2'd3
    } estado_t;

    estado_t     r_estado;
    estado_t     w_prox;

    logic        w_aceita;
    logic        w_rejeita;
    logic        w_pronto;
    logic        w_erro;
    logic        w_ocupado;
    logic        w_re;
    logic        w_we;

    logic [1:0]  r_lane;
    logic [1:0]  r_tamanho;
    logic        r_sinal;
    logic        r_escrita;
    logic        r_erro;
    logic [15:0] r_dado;
    logic [31:0] r_ram_endereco;
    logic [31:0] r_ram_entrada;
    logic [31:0] r_dado_leitura;

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_carga;
    logic [31:0] w_mescla;

    // Request rejection: misalignment, illegal size or word index past the RAM.
    always_comb begin
        w_rejeita = 1'b0;
        case (bus.tamanho)
            2'b01:   w_rejeita = bus.endereco[0];
            2'b10:   w_rejeita = (bus.endereco[1:0] != 2'b00);
            2'b11:   w_rejeita = 1'b1;
            default: ;
        endcase
        if (bus.endereco[31:2] >= 30'(RAM_PALAVRAS)) begin
            w_rejeita = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_prox;
        end
    end

    // Next-state and state-decoded outputs; a reset edge suppresses the write strobe.
    always_comb begin
        w_prox    = r_estado;
        w_aceita  = 1'b0;
        w_pronto  = 1'b0;
        w_erro    = 1'b0;
        w_ocupado = 1'b1;
        w_re      = 1'b0;
        w_we      = 1'b0;
        case (r_estado)
            OCIOSO: begin
                w_ocupado = 1'b0;
                if (bus.inicio) begin
                    w_aceita = 1'b1;
                    if (w_rejeita) begin
                        w_prox = CONCLUIR;
                    end else if (bus.escrita && (bus.tamanho == 2'b10)) begin
                        w_prox = ESCREVER;
                    end else begin
                        w_prox = LER;
                    end
                end
            end
            LER: begin
                w_re   = 1'b1;
                w_prox = r_escrita ? ESCREVER : CONCLUIR;
            end
            ESCREVER: begin
                w_we   = rst_n;
                w_prox = CONCLUIR;
            end
            CONCLUIR: begin
                w_pronto = 1'b1;
                w_erro   = r_erro;
                w_prox   = OCIOSO;
            end
            default: w_prox = OCIOSO;
        endcase
    end

    // Lane extraction for loads and lane merge for sub-word stores (little-endian).
    always_comb begin
        w_byte   = bus.ram_saida[{r_lane, 3'b000} +: 8];
        w_half   = bus.ram_saida[{r_lane[1], 4'b0000} +: 16];
        w_carga  = bus.ram_saida;
        w_mescla = bus.ram_saida;
        case (r_tamanho)
            2'b00: begin
                w_carga = r_sinal ? {{24{w_byte[7]}}, w_byte} : {24'h000000, w_byte};
                w_mescla[{r_lane, 3'b000} +: 8] = r_dado[7:0];
            end
            2'b01: begin
                w_carga = r_sinal ? {{16{w_half[15]}}, w_half} : {16'h0000, w_half};
                w_mescla[{r_lane[1], 4'b0000} +: 16] = r_dado;
            end
            default: ;
        endcase
    end

    // Request latch, write-word staging and load result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lane         <= 2'b00;
            r_tamanho      <= 2'b00;
            r_sinal        <= 1'b0;
            r_escrita      <= 1'b0;
            r_erro         <= 1'b0;
            r_dado         <= 16'h0000;
            r_ram_endereco <= 32'h0000_0000;
            r_ram_entrada  <= 32'h0000_0000;
            r_dado_leitura <= 32'h0000_0000;
        end else begin
            if (w_aceita) begin
                r_ram_endereco <= {2'b00, bus.endereco[31:2]};
                r_lane         <= bus.endereco[1:0];
                r_tamanho      <= bus.tamanho;
                r_sinal        <= bus.sinal;
                r_escrita      <= bus.escrita;
                r_dado         <= bus.dado_escrita[15:0];
                r_erro         <= w_rejeita;
                if (!w_rejeita && bus.escrita && (bus.tamanho == 2'b10)) begin
                    r_ram_entrada <= bus.dado_escrita;
                end
            end
            if (r_estado == LER) begin
                if (r_escrita) begin
                    r_ram_entrada <= w_mescla;
                end else begin
                    r_dado_leitura <= w_carga;
                end
            end
        end
    end

    assign bus.dado_leitura     = r_dado_leitura;
    assign bus.pronto           = w_pronto;
    assign bus.erro_alinhamento = w_erro;
    assign bus.ocupado          = w_ocupado;
    assign bus.ram_endereco     = r_ram_endereco;
    assign bus.ram_entrada      = r_ram_entrada;
    assign bus.ram_we           = w_we;
    assign bus.ram_re           = w_re;

endmodule

// File: tb/tb_unidade_load_store.sv
// Scoreboard bench for unidade_load_store with a behavioural RAM and reference model.
module tb_unidade_load_store;

    localparam int unsigned PALAVRAS = 1024;

    typedef struct {
        logic        esc;
        logic [1:0]  tam;
        logic        sin;
        logic [31:0] ende;
        logic [31:0] dado;
    } req_t;

    typedef struct {
        int unsigned ciclo;
        logic        erro;
        logic [31:0] dado;
        logic [31:0] idx;
        int unsigned n_re;
        int unsigned n_we;
    } esp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ram_init;
    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    logic [31:0] mem     [0:PALAVRAS-1];
    logic [31:0] ref_mem [0:PALAVRAS-1];
    logic [31:0] ref_ultimo;
    esp_t        sb[$];

    always #5 clk = ~clk;

    unidade_load_store_if bus();

    unidade_load_store #(.RAM_PALAVRAS(PALAVRAS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] padrao(input int unsigned i);
        if (i == 3) return 32'h80817F63;
        return (32'(i) * 32'h9E3779B9) ^ 32'h1234_5678;
    endfunction

    // Data RAM: combinational read, write commits on the clock edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_init) begin
            for (int i = 0; i < PALAVRAS; i++) mem[i] <= padrao(i);
        end else if (bus.ram_we) begin
            mem[bus.ram_endereco[9:0]] <= bus.ram_entrada;
        end
    end

    assign bus.ram_saida = (bus.ram_endereco < 32'(PALAVRAS)) ? mem[bus.ram_endereco[9:0]] : 32'h0;

    task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nome, got, exp);
        end
    endtask

    // Reference: expected completion for a request, updating the model memory.
    function automatic esp_t modelo(input req_t r, input int unsigned c0);
        esp_t        e;
        logic [31:0] idx;
        logic [31:0] w;
        logic [31:0] v;
        logic [31:0] mask;
        int unsigned sh;
        logic        rej;
        logic        msb;
        idx = {2'b00, r.ende[31:2]};
        rej = (r.tam == 2'b11) || ((r.tam == 2'b01) && r.ende[0]) ||
              ((r.tam == 2'b10) && (r.ende[1:0] != 2'b00)) || (idx >= 32'(PALAVRAS));
        e.idx = idx; e.erro = rej; e.n_re = 0; e.n_we = 0; e.ciclo = c0;
        if (!rej) begin
            sh   = (r.tam == 2'b00) ? 32'(r.ende[1:0]) * 8 : 32'(r.ende[1]) * 16;
            mask = (r.tam == 2'b00) ? 32'hFF : (r.tam == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
            w    = ref_mem[idx[9:0]];
            if (r.esc) begin
                if (r.tam == 2'b10) begin
                    ref_mem[idx[9:0]] = r.dado;
                    e.n_we = 1; e.ciclo = c0 + 1;
                end else begin
                    ref_mem[idx[9:0]] = (w & ~(mask << sh)) | ((r.dado & mask) << sh);
                    e.n_re = 1; e.n_we = 1; e.ciclo = c0 + 2;
                end
            end else begin
                v   = (w >> sh) & mask;
                msb = (r.tam == 2'b00) ? v[7] : v[15];
                if (r.sin && (r.tam != 2'b10) && msb) v = v | ~mask;
                ref_ultimo = v;
                e.n_re = 1; e.ciclo = c0 + 1;
            end
        end
        e.dado = ref_ultimo;
        return e;
    endfunction

    function automatic req_t mk(input logic esc, input logic [1:0] tam, input logic sin,
                                input logic [31:0] ende, input logic [31:0] dado);
        req_t r;
        r.esc = esc; r.tam = tam; r.sin = sin; r.ende = ende; r.dado = dado;
        return r;
    endfunction

    function automatic req_t req_aleatorio();
        logic [29:0] idx;
        logic [1:0]  tam;
        if ($urandom_range(0, 11) == 0) idx = 30'($urandom_range(1024, 70000));
        else                            idx = 30'($urandom_range(0, 15));
        if ($urandom_range(0, 7) == 0) tam = 2'b11;
        else                           tam = 2'($urandom_range(0, 2));
        return mk(1'($urandom_range(0, 1)), tam, 1'($urandom_range(0, 1)),
                  {idx, 2'($urandom_range(0, 3))}, $urandom);
    endfunction

    task automatic aplicar(input req_t r);
        bus.escrita      = r.esc;
        bus.tamanho      = r.tam;
        bus.sinal        = r.sin;
        bus.endereco     = r.ende;
        bus.dado_escrita = r.dado;
    endtask

    task automatic esperar_ocioso();
        for (int i = 0; i < 20 && bus.ocupado; i++) @(negedge clk);
        check("ocioso_antes_pedido", 32'(bus.ocupado), 32'd0);
    endtask

    task automatic esperar_pronto(input bit agitar, input bit manter);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.pronto) begin
                ok = 1'b1;
                if (!manter) bus.inicio = 1'b0;
                break;
            end
            if (agitar) begin
                aplicar(req_aleatorio());
                bus.inicio = 1'($urandom_range(0, 1));
            end
        end
        check("timeout_pronto", 32'(ok), 32'd1);
    endtask

    task automatic emitir(input req_t r, input bit agitar);
        @(negedge clk);
        esperar_ocioso();
        aplicar(r);
        bus.inicio = 1'b1;
        @(posedge clk);
        #1;
        bus.inicio = 1'b0;
        sb.push_back(modelo(r, cyc));
        esperar_pronto(agitar, 1'b0);
    endtask

    // Second request held on inicio through the first one's completion.
    task automatic emitir_par(input req_t a, input req_t b);
        @(negedge clk);
        esperar_ocioso();
        aplicar(a);
        bus.inicio = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(modelo(a, cyc));
        aplicar(b);
        esperar_pronto(1'b0, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.inicio = 1'b0;
        sb.push_back(modelo(b, cyc));
        esperar_pronto(1'b0, 1'b0);
    endtask

    // Monitor: counts strobes per transaction and checks each pronto against the scoreboard.
    initial begin
        esp_t        e;
        int unsigned cnt_re;
        int unsigned cnt_we;
        cnt_re = 0;
        cnt_we = 0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                cnt_re = 0;
                cnt_we = 0;
            end else begin
                check("strobes_exclusivos", 32'(bus.ram_re & bus.ram_we), 32'd0);
                check("erro_sem_pronto", 32'(bus.erro_alinhamento & ~bus.pronto), 32'd0);
                if (sb.size() > 0) begin
                    if (bus.ram_re) cnt_re++;
                    if (bus.ram_we) cnt_we++;
                    if (bus.ram_re || bus.ram_we)
                        check("ram_endereco_strobe", bus.ram_endereco, sb[0].idx);
                end
                if (bus.pronto) begin
                    if (sb.size() == 0) begin
                        check("pronto_inesperado", 32'(bus.pronto), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("latencia", 32'(cyc), 32'(e.ciclo));
                        check("erro_alinhamento", 32'(bus.erro_alinhamento), 32'(e.erro));
                        check("dado_leitura", bus.dado_leitura, e.dado);
                        check("ram_endereco", bus.ram_endereco, e.idx);
                        check("n_ram_re", 32'(cnt_re), 32'(e.n_re));
                        check("n_ram_we", 32'(cnt_we), 32'(e.n_we));
                    end
                    cnt_re = 0;
                    cnt_we = 0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst_n    = 1'b0;
        ram_init = 1'b1;
        bus.inicio = 1'b1;
        aplicar(mk(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0));
        for (int i = 0; i < PALAVRAS; i++) ref_mem[i] = padrao(i);
        ref_ultimo = 32'h0;

        // Reset held with a request pending: everything quiet.
        repeat (2) begin
            @(negedge clk);
            check("rst_dado_leitura", bus.dado_leitura, 32'h0);
            check("rst_ram_endereco", bus.ram_endereco, 32'h0);
            check("rst_ram_entrada", bus.ram_entrada, 32'h0);
            check("rst_pronto", 32'(bus.pronto), 32'd0);
            check("rst_erro", 32'(bus.erro_alinhamento), 32'd0);
            check("rst_ocupado", 32'(bus.ocupado), 32'd0);
            check("rst_ram_re", 32'(bus.ram_re), 32'd0);
            check("rst_ram_we", 32'(bus.ram_we), 32'd0);
        end
        bus.inicio = 1'b0;
        rst_n      = 1'b1;
        ram_init   = 1'b0;

        // Loads from word 3 = 0x80817F63.
        emitir(mk(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0), 1'b0);
        check("carga_palavra", bus.dado_leitura, 32'h80817F63);
        emitir(mk(1'b0, 2'b00, 1'b1, 32'h0D, 32'h0), 1'b0);
        check("carga_byte_s_0d", bus.dado_leitura, 32'h0000007F);
        emitir(mk(1'b0, 2'b00, 1'b1, 32'h0F, 32'h0), 1'b0);
        check("carga_byte_s_0f", bus.dado_leitura, 32'hFFFFFF80);
        emitir(mk(1'b0, 2'b00, 1'b0, 32'h0F, 32'h0), 1'b0);
        check("carga_byte_u_0f", bus.dado_leitura, 32'h00000080);
        emitir(mk(1'b0, 2'b01, 1'b1, 32'h0E, 32'h0), 1'b0);
        check("carga_half_s_0e", bus.dado_leitura, 32'hFFFF8081);

        // Byte store read-modify-write, then word store and read back.
        emitir(mk(1'b1, 2'b00, 1'b0, 32'h0D, 32'h1234_56AB), 1'b0);
        check("mem3_byte_store", mem[3], 32'h8081AB63);
        emitir(mk(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF), 1'b0);
        check("mem4_word_store", mem[4], 32'hDEADBEEF);
        emitir(mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0), 1'b0);
        check("leitura_word_store", bus.dado_leitura, 32'hDEADBEEF);

        // Rejected requests leave dado_leitura alone.
        emitir(mk(1'b0, 2'b10, 1'b0, 32'h0E, 32'h0), 1'b0);
        emitir(mk(1'b0, 2'b01, 1'b1, 32'h0F, 32'h0), 1'b0);
        emitir(mk(1'b1, 2'b11, 1'b0, 32'h08, 32'h5555_5555), 1'b0);
        emitir(mk(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0), 1'b0);
        check("rejeicao_mantem_dado", bus.dado_leitura, 32'hDEADBEEF);

        // inicio toggled while busy; back-to-back with inicio held.
        emitir(mk(1'b1, 2'b01, 1'b0, 32'h0E, 32'h0000_C3C3), 1'b1);
        emitir_par(mk(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0), mk(1'b0, 2'b00, 1'b0, 32'h0F, 32'h0));

        // Reset on the ESCREVER edge: write suppressed, no pronto.
        @(negedge clk);
        esperar_ocioso();
        aplicar(mk(1'b1, 2'b00, 1'b0, 32'h0D, 32'h0000_0055));
        bus.inicio = 1'b1;
        @(posedge clk);
        #1;
        bus.inicio = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.ram_we) begin
                ok = 1'b1;
                break;
            end
        end
        check("chegou_escrever", 32'(ok), 32'd1);
        rst_n = 1'b0;
        #1;
        check("we_suprimido_reset", 32'(bus.ram_we), 32'd0);
        @(posedge clk);
        #1;
        ref_ultimo = 32'h0;
        check("mem3_intacta_reset", mem[3], ref_mem[3]);
        check("ocupado_pos_reset", 32'(bus.ocupado), 32'd0);
        check("pronto_pos_reset", 32'(bus.pronto), 32'd0);
        check("dado_leitura_pos_reset", bus.dado_leitura, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Randomised traffic against the reference model.
        for (int n = 0; n < 150; n++) begin
            if ((n % 10) == 9) emitir_par(req_aleatorio(), req_aleatorio());
            else               emitir(req_aleatorio(), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 16; i++) check("mem_final", mem[i], ref_mem[i]);

        repeat (3) @(negedge clk);
        check("fila_vazia", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
